// File: rtl/memory_arbiter.sv
// memory_arbiter: N-client front end for memory_unit.
// Picks one requester (fixed priority or round-robin, with an optional
// ownership lock), drives the execute/busy/ready handshake itself and
// returns a one-cycle done pulse plus shared read data to the owner.
module memory_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter bit RR_MODE     = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENTS-1:0]            req,
  input  logic [NUM_CLIENTS-1:0]            req_lock,
  input  logic [2*NUM_CLIENTS-1:0]          req_func,
  input  logic [ADDR_WIDTH*NUM_CLIENTS-1:0] req_address,
  input  logic [DATA_WIDTH*NUM_CLIENTS-1:0] req_write_data,
  output logic [NUM_CLIENTS-1:0]            grant,
  output logic [NUM_CLIENTS-1:0]            done,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic                              busy,
  output logic                              mem_execute,
  output logic [1:0]                        mem_func,
  output logic [ADDR_WIDTH-1:0]             mem_address,
  output logic [DATA_WIDTH-1:0]             mem_write_data,
  input  logic [DATA_WIDTH-1:0]             mem_read_data,
  input  logic                              mem_ready
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [NUM_CLIENTS-1:0]   grant_q, grant_d;
  idx_t                     owner_q, owner_d;
  idx_t                     rr_ptr_q, rr_ptr_d;
  logic                     lock_vld_q, lock_vld_d;
  idx_t                     lock_own_q, lock_own_d;
  logic [1:0]               mem_func_q, mem_func_d;
  logic [ADDR_WIDTH-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

  logic [1:0]               func_arr  [NUM_CLIENTS];
  logic [ADDR_WIDTH-1:0]    addr_arr  [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0]    wdata_arr [NUM_CLIENTS];

  idx_t                     sel_idx;
  logic                     sel_found;
  idx_t                     win;
  logic                     lock_hit;

  // Split the packed per-client request fields into indexable arrays.
  always_comb begin
    for (int c = 0; c < NUM_CLIENTS; c++) begin
      func_arr[c]  = req_func[2*c +: 2];
      addr_arr[c]  = req_address[ADDR_WIDTH*c +: ADDR_WIDTH];
      wdata_arr[c] = req_write_data[DATA_WIDTH*c +: DATA_WIDTH];
    end
  end

  // Normal winner: first requester scanning from the RR pointer (or from 0).
  always_comb begin
    int c;
    c         = 0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      c = RR_MODE ? (int'(rr_ptr_q) + k) : k;
      if (c >= NUM_CLIENTS) c = c - NUM_CLIENTS;
      if (!sel_found && req[idx_t'(c)]) begin
        sel_found = 1'b1;
        sel_idx   = idx_t'(c);
      end
    end
  end

  // Handshake sequencer: next state, grant, lock and captured fields.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    lock_vld_d  = lock_vld_q;
    lock_own_d  = lock_own_q;
    mem_func_d  = mem_func_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    lock_hit    = lock_vld_q && req[lock_own_q];
    win         = lock_hit ? lock_own_q : sel_idx;

    case (state_q)
      IDLE: begin
        // An owner that dropped its request gives up the lock immediately.
        if (lock_vld_q && !req[lock_own_q]) lock_vld_d = 1'b0;
        if ((req != '0) && mem_ready) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          owner_d      = win;
          mem_func_d   = func_arr[win];
          mem_addr_d   = addr_arr[win];
          mem_wdata_d  = wdata_arr[win];
          // Locked re-grants do not move the rotation.
          if (RR_MODE && !lock_hit)
            rr_ptr_d = (win == idx_t'(NUM_CLIENTS-1)) ? '0 : win + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!mem_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mem_ready) begin
          rdata_d = mem_read_data;
          state_d = DONE;
        end
      end
      DONE: begin
        lock_vld_d = req_lock[owner_q];
        lock_own_d = owner_q;
        grant_d    = '0;
        state_d    = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      lock_vld_q  <= 1'b0;
      lock_own_q  <= '0;
      mem_func_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_vld_q  <= lock_vld_d;
      lock_own_q  <= lock_own_d;
      mem_func_q  <= mem_func_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign grant          = grant_q;
  assign done           = (state_q == DONE) ? grant_q : '0;
  assign rdata          = rdata_q;
  assign busy           = (state_q != IDLE);
  assign mem_execute    = (state_q == ISSUE);
  assign mem_func       = mem_func_q;
  assign mem_address    = mem_addr_q;
  assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with 4 clients: a round-robin instance
// and a fixed-priority instance, each with its own simple memory model.
module tb_memory_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_lock;
  logic [2*N-1:0]  req_func;
  logic [AW*N-1:0] req_address;
  logic [DW*N-1:0] req_write_data;

  logic [N-1:0]  g0, d0, g1, d1;
  logic [DW-1:0] rd0, rd1, mwd0, mwd1, mrd0, mrd1;
  logic [AW-1:0] ma0, ma1;
  logic [1:0]    mf0, mf1;
  logic          bz0, bz1, mex0, mex1, mrdy0, mrdy1;

  int busy_len;
  int cnt0, cnt1;
  int exec_cnt0, done_cnt0, overlap0, subset_bad0;
  logic [DW-1:0] mem0 [0:255];
  logic [DW-1:0] mem1 [0:255];

  int errors;
  int checks;

  memory_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .req_lock(req_lock), .req_func(req_func),
    .req_address(req_address), .req_write_data(req_write_data),
    .grant(g0), .done(d0), .rdata(rd0), .busy(bz0), .mem_execute(mex0),
    .mem_func(mf0), .mem_address(ma0), .mem_write_data(mwd0),
    .mem_read_data(mrd0), .mem_ready(mrdy0)
  );

  memory_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .req(req), .req_lock(req_lock), .req_func(req_func),
    .req_address(req_address), .req_write_data(req_write_data),
    .grant(g1), .done(d1), .rdata(rd1), .busy(bz1), .mem_execute(mex1),
    .mem_func(mf1), .mem_address(ma1), .mem_write_data(mwd1),
    .mem_read_data(mrd1), .mem_ready(mrdy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model for the round-robin instance: ready drops for busy_len cycles after execute.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mrdy0 <= 1'b1;
      cnt0  <= 0;
      mrd0  <= '0;
    end else if (mex0) begin
      mrdy0 <= 1'b0;
      cnt0  <= busy_len;
      if (mf0 == 2'd2) mem0[ma0[7:0]] <= mwd0;
      else             mrd0 <= mem0[ma0[7:0]];
    end else if (cnt0 > 1) begin
      cnt0 <= cnt0 - 1;
    end else if (cnt0 == 1) begin
      cnt0  <= 0;
      mrdy0 <= 1'b1;
    end
  end

  // Memory model for the fixed-priority instance.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mrdy1 <= 1'b1;
      cnt1  <= 0;
      mrd1  <= '0;
    end else if (mex1) begin
      mrdy1 <= 1'b0;
      cnt1  <= busy_len;
      if (mf1 == 2'd2) mem1[ma1[7:0]] <= mwd1;
      else             mrd1 <= mem1[ma1[7:0]];
    end else if (cnt1 > 1) begin
      cnt1 <= cnt1 - 1;
    end else if (cnt1 == 1) begin
      cnt1  <= 0;
      mrdy1 <= 1'b1;
    end
  end

  // Event counters and invariant monitors on the round-robin instance.
  initial begin
    exec_cnt0 = 0; done_cnt0 = 0; overlap0 = 0; subset_bad0 = 0;
  end
  always @(posedge clk) begin
    if (mex0) exec_cnt0 <= exec_cnt0 + 1;
    if (d0 != '0) done_cnt0 <= done_cnt0 + 1;
    if ($countones(d0) > 1 || $countones(g0) > 1) overlap0 <= overlap0 + 1;
    if ((d0 & ~g0) != '0) subset_bad0 <= subset_bad0 + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_client(input int c, input logic [1:0] f, input logic [15:0] a,
                            input logic [15:0] d);
    req_func[2*c +: 2]        = f;
    req_address[AW*c +: AW]   = a;
    req_write_data[DW*c +: DW] = d;
  endtask

  // Advance until the round-robin instance pulses done; returns cycles taken.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (d0 == '0 && cyc < 40);
    if (d0 == '0) begin
      checks++;
      errors++;
      $error("FAIL %s: no done within %0d cycles", tag, cyc);
    end
  endtask

  initial begin
    int cyc;
    int e0, dc0;
    logic [N-1:0] rr_exp [5];
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    errors = 0; checks = 0; busy_len = 1;
    rst = 1'b0; req = '0; req_lock = '0;
    req_func = '0; req_address = '0; req_write_data = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("reset_grant", g0, 0);
    check("reset_done", d0, 0);
    check("reset_busy", bz0, 0);
    check("reset_exec", mex0, 0);
    check("reset_rdata", rd0, 0);

    // Write: client 0, addr 5, data 0xAB.
    set_client(0, 2'd2, 16'd5, 16'h00AB);
    req = 4'b0001;
    tick();
    check("wr_exec", mex0, 1);
    check("wr_grant", g0, 4'b0001);
    check("wr_addr", ma0, 16'd5);
    check("wr_data", mwd0, 16'h00AB);
    check("wr_func", mf0, 2);
    tick();
    check("wr_exec_one_cycle", mex0, 0);
    check("wr_addr_held", ma0, 16'd5);
    wait_done("wr", cyc);
    check("wr_latency", cyc + 2, 4);
    check("wr_done", d0, 4'b0001);
    req = '0;
    tick();
    check("wr_done_once", d0, 0);
    check("wr_grant_clear", g0, 0);
    check("wr_mem_stored", mem0[5], 16'h00AB);

    // Store 0x1234 at addr 7, then read it back with a 3-cycle busy.
    set_client(0, 2'd2, 16'd7, 16'h1234);
    req = 4'b0001;
    wait_done("wr7", cyc);
    req = '0;
    tick();
    busy_len = 3;
    set_client(0, 2'd1, 16'd7, 16'h0000);
    req = 4'b0001;
    wait_done("rd", cyc);
    check("rd_latency", cyc, 6);
    check("rd_rdata", rd0, 16'h1234);
    req = '0;
    tick();
    check("rd_rdata_hold", rd0, 16'h1234);
    check("rd_idle_busy", bz0, 0);

    // All four clients request continuously after a fresh reset.
    busy_len = 1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int c = 0; c < N; c++) set_client(c, 2'd1, 16'(c), 16'h0000);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_done("rr", cyc);
      check("rr_order", d0, rr_exp[i]);
      check("fp_order", d1, 4'b0001);
    end
    req = '0;
    tick();
    tick();

    // Client 2 holds the lock for three transactions while client 0 waits.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req = 4'b0100;
    req_lock = 4'b0100;
    wait_done("lock1", cyc);
    check("lock_grant1", d0, 4'b0100);
    req = 4'b0101;
    wait_done("lock2", cyc);
    check("lock_grant2", d0, 4'b0100);
    wait_done("lock3", cyc);
    check("lock_grant3", d0, 4'b0100);
    check("lock_ptr", dut.rr_ptr_q, 3);
    req_lock = '0;
    req = 4'b0001;
    wait_done("lock4", cyc);
    check("lock_grant4", d0, 4'b0001);
    check("lock_ptr_after", dut.rr_ptr_q, 1);
    req = '0;
    tick();

    // Asynchronous reset while waiting for memory completion.
    busy_len = 5;
    set_client(1, 2'd1, 16'd7, 16'h0000);
    req = 4'b0010;
    tick();
    tick();
    tick();
    check("arst_pre_busy", bz0, 1);
    check("arst_pre_grant", g0, 4'b0010);
    #2;
    rst = 1'b0;
    #1;
    check("arst_grant", g0, 0);
    check("arst_busy", bz0, 0);
    check("arst_exec", mex0, 0);
    check("arst_addr", ma0, 0);
    check("arst_rdata", rd0, 0);
    req = '0;
    tick();
    tick();
    rst = 1'b1;
    busy_len = 1;
    dc0 = done_cnt0;
    set_client(3, 2'd2, 16'd9, 16'h0055);
    req = 4'b1000;
    wait_done("arst_fresh", cyc);
    check("arst_fresh_done", d0, 4'b1000);
    check("arst_fresh_latency", cyc, 4);
    req = '0;
    tick();
    tick();
    check("arst_no_stray_done", done_cnt0 - dc0, 1);

    // Client 1 arrives while client 0 is in flight.
    busy_len = 2;
    e0 = exec_cnt0;
    dc0 = done_cnt0;
    set_client(0, 2'd2, 16'd3, 16'h0C0D);
    set_client(1, 2'd1, 16'd3, 16'h0000);
    req = 4'b0001;
    tick();
    req = 4'b0011;
    wait_done("seq0", cyc);
    check("seq_done0", d0, 4'b0001);
    req = 4'b0010;
    tick();
    check("seq_idle_done", d0, 0);
    check("seq_idle_grant", g0, 0);
    tick();
    check("seq_issue1_grant", g0, 4'b0010);
    check("seq_issue1_exec", mex0, 1);
    wait_done("seq1", cyc);
    check("seq_done1", d0, 4'b0010);
    check("seq_rdata", rd0, 16'h0C0D);
    req = '0;
    tick();
    tick();
    check("seq_exec_count", exec_cnt0 - e0, 2);
    check("seq_done_count", done_cnt0 - dc0, 2);
    check("onehot_violations", overlap0, 0);
    check("done_subset_violations", subset_bad0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- N-client arbiter in front of memory_unit; generalises the 2-way combinational memory_mux (MTU/NEM) to NUM_CLIENTS requesters.
- Performs the full memory handshake itself: execute pulse, wait for busy, wait for ready.
- Arbitration is selectable between fixed-priority and round-robin.
- Adds a lock that lets a client keep ownership across back-to-back transactions, e.g. NEM read-modify-write sequences.

Parameters:
- NUM_CLIENTS, 2, number of requesters (2..8)
- ADDR_WIDTH, `memory_addr_width, memory address width
- DATA_WIDTH, `memory_data_width, memory data width
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- req  input  NUM_CLIENTS  per-client request level
- req_lock  input  NUM_CLIENTS  per-client request to keep the grant after this transaction
- req_func  input  2*NUM_CLIENTS  packed memory func; client i at [2i+1:2i]
- req_address  input  ADDR_WIDTH*NUM_CLIENTS  packed address
- req_write_data  input  DATA_WIDTH*NUM_CLIENTS  packed write data
- grant  output  NUM_CLIENTS  one-hot owner of the in-flight transaction
- done  output  NUM_CLIENTS  one-cycle completion pulse to the owner
- rdata  output  DATA_WIDTH  read data captured at completion; shared by all clients
- busy  output  1  high in any state other than IDLE
- mem_execute  output  1  to memory_unit execute
- mem_func  output  2  to memory_unit func
- mem_address  output  ADDR_WIDTH  to memory_unit address
- mem_write_data  output  DATA_WIDTH  to memory_unit write_data
- mem_read_data  input  DATA_WIDTH  from memory_unit read_data
- mem_ready  input  1  from memory_unit is_ready

Behaviour:
- Reset (rst low, asynchronous):
  - all outputs 0; state IDLE; RR pointer 0; lock owner cleared.
  - Any in-flight memory operation is abandoned. Memory state is the system's responsibility.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE:
  - if (req != 0) and mem_ready: select winner, register grant and the winner's func/address/write_data into mem_* registers, go to ISSUE.
  - otherwise stay.
  - Requests are sampled only in IDLE.
- Selection:
  - If a lock owner is held and its req is high, the owner wins regardless of mode.
  - If the lock owner's req is low, the lock clears and normal selection runs in the same cycle.
  - RR_MODE=0: lowest set index wins.
  - RR_MODE=1: first set index at or after the pointer, wrapping modulo NUM_CLIENTS. The pointer updates to (winner+1) mod NUM_CLIENTS on grant; it is not advanced on a locked re-grant.
- ISSUE: mem_execute=1 for exactly this one cycle; mem_* stable; next WAIT_BUSY.
- WAIT_BUSY: wait for mem_ready=0, then WAIT_DONE. mem_* held stable.
- WAIT_DONE: on mem_ready=1, capture mem_read_data into rdata, go to DONE.
- DONE:
  - done[owner]=1 for one cycle.
  - Lock owner set to the owner if req_lock[owner]=1 this cycle, else cleared.
  - grant clears at the exit edge; next state IDLE.
- Client rule:
  - hold req and the request fields stable from assertion until done.
  - deassert req (or present the next request) by the edge after done.
  - The idle cycle after DONE gives registered clients time to do this.
- Latency: request seen in IDLE at cycle N → mem_execute at N+1 → done at (cycle mem_ready returns high)+1. Minimum request-to-done is 4 cycles.
- Invariants:
  - grant is one-hot or zero; it is nonzero exactly in ISSUE..DONE.
  - done is always a subset of grant.
  - mem_execute is never high outside ISSUE.
- Simultaneous events:
  - A req from a non-owner while busy is ignored until IDLE; no queueing.
  - Equal requests in RR mode rotate fairly: no client waits more than NUM_CLIENTS−1 grants.
- rdata holds its value until the next completion; it is not cleared in IDLE.
- mem_ready low while in IDLE: no grant issued; requests wait.

Test Plan:
- Reset, mem model ready; req=2'b01, func=2 (write), addr=5, wdata=0xAB → mem_execute one cycle with addr 5/data 0xAB; done=2'b01 once; grant=0 afterwards.
- Read: memory returns 0x1234 after a 3-cycle busy → rdata=0x1234 in the done cycle; request-to-done = 3 + 3 cycles.
- RR_MODE=1, NUM_CLIENTS=4, req=4'b1111 held continuously → grant order 0,1,2,3,0; RR_MODE=0 under the same stimulus → grant always 0.
- Client 2 asserts req_lock over 3 transactions while client 0 requests → grants 2,2,2,0; the pointer after the locked run is 3.
- rst driven low during WAIT_DONE → outputs 0 immediately (asynchronous); after release, a fresh req is served normally and there is no stray done.
- Client 1 asserts req while client 0 is in flight → client 1 is served after client 0's DONE+IDLE; done never overlaps and mem_execute pulses exactly twice.
